block_stacker: RTL and testbench
================================

BLOCK_STACKER -- requirements
Module: block_stacker

Interface
REQ-001 SHALL provide parameter X_MAX, default 144, meaning right-most legal left-edge pixel of the moving block.
REQ-002 SHALL provide parameter INIT_X, default 52, meaning left edge of the base block after reset.
REQ-003 SHALL provide parameter INIT_WIDTH, default 40, meaning width in pixels of the base block after reset.
REQ-004 SHALL provide parameter MAX_LEVEL, default 20, meaning number of placed blocks that wins the game.
REQ-005 SHALL provide port: clk  input  1  system clock, all logic on posedge.
REQ-006 SHALL provide port: reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL provide port: drop  input  1  single-cycle player drop request.
REQ-008 SHALL provide port: curr_x  input  8  left edge of the moving block, from the x register.
REQ-009 SHALL provide port: enable_x  output  1  enable for the x register; high only while the block may move.
REQ-010 SHALL provide port: top_x  output  8  left edge of the top placed block.
REQ-011 SHALL provide port: top_width  output  8  width of the top placed block; also the width of the moving block.
REQ-012 SHALL provide port: level  output  5  count of blocks placed since reset.
REQ-013 SHALL provide port: done  output  1  one-cycle pulse when a placement commits.
REQ-014 SHALL provide port: perfect  output  1  one-cycle pulse, coincident with done, on a snapped placement.
REQ-015 SHALL provide port: game_over  output  1  high, sticky, when a drop misses the stack.
REQ-016 SHALL provide port: win  output  1  high, sticky, when level reaches MAX_LEVEL.

Function
REQ-017 SHALL implement FSM states MOVE, CALC, PLACE, OVER, WIN.
REQ-018 SHALL, in MOVE with drop high, latch curr_x into cand_x and enter CALC next cycle.
REQ-019 SHALL ignore drop in every state other than MOVE.
REQ-020 SHALL drive enable_x high only in MOVE, registered, so it falls the cycle after an accepted drop.
REQ-021 SHALL, in CALC, compute in 9-bit unsigned arithmetic: left = max(cand_x, top_x); right = min(cand_x + top_width, top_x + top_width).
REQ-022 SHALL, in CALC, enter OVER if right <= left; otherwise latch new_x = left, new_w = right - left and enter PLACE.
REQ-023 SHALL, in PLACE, load top_x = new_x, top_width = new_w, level = level + 1, pulse done for one cycle.
REQ-024 SHALL give latency: drop accepted at edge N -> done high during cycle N+2 -> enable_x high again at cycle N+3 unless WIN.
REQ-025 SHALL leave PLACE for WIN if the incremented level equals MAX_LEVEL, else for MOVE.
REQ-026 SHALL hold OVER and WIN until reset; top_x, top_width and level stay frozen there.
REQ-027 SHALL assert game_over in every OVER cycle and win in every WIN cycle.
REQ-028 SHALL treat curr_x > X_MAX as legal input and still apply REQ-021/022.

Reset
REQ-029 SHALL, on reset high at a clk edge, set state MOVE, top_x = INIT_X, top_width = INIT_WIDTH, level = 0, enable_x = 1, done = perfect = game_over = win = 0.
REQ-030 SHALL give reset priority over drop and over any state, including mid-CALC or mid-PLACE; any pending placement is discarded.

Configuration
REQ-031 SHALL recognise macro BLOCK_STACKER_PERFECT_SNAP_EN.
REQ-032 SHALL, with the macro defined, in CALC, if |cand_x - top_x| <= 1, set new_x = top_x, new_w = top_width, and pulse perfect with done.
REQ-033 SHALL, without the macro, always use REQ-022 and tie perfect to 0.

Verification
REQ-034 SHALL cover reset: assert reset 1 cycle -> top_x = 52, top_width = 40, level = 0, enable_x = 1, game_over = 0.
REQ-035 SHALL cover right overhang: after reset, drop with curr_x = 60 -> done at N+2, top_x = 60, top_width = 32, level = 1.
REQ-036 SHALL cover left overhang: after reset, drop with curr_x = 30 -> top_x = 52, top_width = 18, level = 1.
REQ-037 SHALL cover a miss: after reset, drop with curr_x = 100 -> game_over = 1, no done, top_x = 52, top_width = 40, enable_x = 0; later drops ignored.
REQ-038 SHALL cover snap: after reset, drop with curr_x = 53 -> with macro top_x = 52, top_width = 40, perfect = 1; without macro top_x = 53, top_width = 39, perfect = 0.
REQ-039 SHALL cover win and reset: MAX_LEVEL = 2, two drops at curr_x = 52 -> win = 1 after the second done, enable_x = 0; reset asserted during CALC -> all outputs match REQ-029.

Source files
------------

// File: rtl/block_stacker.sv
// block_stacker: control core of a stacking game. A block slides left and
// right. Each drop trims the block to the part that overlaps the block below
// it. A drop that overlaps nothing ends the game, and reaching MAX_LEVEL
// placements wins it.
// Optional feature: define BLOCK_STACKER_PERFECT_SNAP_EN to snap a drop that
// lands within one pixel of the block below. A snapped drop keeps the full
// width, and perfect pulses together with done.
module block_stacker #(
  parameter int X_MAX      = 144,
  parameter int INIT_X     = 52,
  parameter int INIT_WIDTH = 40,
  parameter int MAX_LEVEL  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drop,
  input  logic [7:0] curr_x,
  output logic       enable_x,
  output logic [7:0] top_x,
  output logic [7:0] top_width,
  output logic [4:0] level,
  output logic       done,
  output logic       perfect,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    S_MOVE  = 3'd0,
    S_CALC  = 3'd1,
    S_PLACE = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  // The x register may carry positions past X_MAX. Those positions are still
  // legal drops, so X_MAX only has to fit the 8-bit position bus.
  if (X_MAX > 255 || INIT_X > 255 || INIT_WIDTH > 255 || MAX_LEVEL > 31) begin : g_bad_param
    $error("block_stacker: parameter out of range for 8-bit positions / 5-bit level");
  end

  state_t     state_reg;
  logic [7:0] cand_x_reg;
  logic [7:0] new_x_reg;
  logic [7:0] new_w_reg;

  // Overlap arithmetic is done in 9 bits so that x + width cannot wrap.
  logic [8:0] cand9;
  logic [8:0] top9;
  logic [8:0] left9;
  logic [8:0] right9;
  logic [8:0] cand_end9;
  logic [8:0] top_end9;
  logic [7:0] overlap_w;
  logic       miss;
  logic [4:0] level_inc;

  // Compute the overlap of the candidate drop with the top block.
  always_comb begin
    cand9     = {1'b0, cand_x_reg};
    top9      = {1'b0, top_x};
    cand_end9 = cand9 + {1'b0, top_width};
    top_end9  = top9 + {1'b0, top_width};
    left9     = (cand9 > top9) ? cand9 : top9;
    right9    = (cand_end9 < top_end9) ? cand_end9 : top_end9;
    miss      = (right9 <= left9);
    overlap_w = 8'(right9 - left9);
    level_inc = level + 5'd1;
  end

`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
  logic snap;
  logic snap_reg;

  // A drop within one pixel of the top block counts as perfectly aligned.
  always_comb begin
    snap = (cand9 == top9) || (cand9 == top9 + 9'd1) || (cand9 + 9'd1 == top9);
  end
`else
  logic snap;
  assign snap    = 1'b0;
  assign perfect = 1'b0;
`endif

  // Game FSM. All outputs are registered. enable_x follows the MOVE state
  // one cycle late, so the x register freezes right after a drop and restarts
  // one cycle after the placement commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_MOVE;
      cand_x_reg <= 8'd0;
      new_x_reg  <= 8'd0;
      new_w_reg  <= 8'd0;
      top_x      <= 8'(INIT_X);
      top_width  <= 8'(INIT_WIDTH);
      level      <= 5'd0;
      enable_x   <= 1'b1;
      done       <= 1'b0;
      game_over  <= 1'b0;
      win        <= 1'b0;
`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
      snap_reg   <= 1'b0;
      perfect    <= 1'b0;
`endif
    end else begin
      enable_x <= (state_reg == S_MOVE);
      done     <= 1'b0;
`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
      perfect  <= 1'b0;
`endif
      case (state_reg)
        S_MOVE: begin
          if (drop) begin
            cand_x_reg <= curr_x;
            state_reg  <= S_CALC;
          end
        end
        S_CALC: begin
          if (snap) begin
            new_x_reg <= top_x;
            new_w_reg <= top_width;
            state_reg <= S_PLACE;
          end else if (miss) begin
            game_over <= 1'b1;
            state_reg <= S_OVER;
          end else begin
            new_x_reg <= left9[7:0];
            new_w_reg <= overlap_w;
            state_reg <= S_PLACE;
          end
`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
          snap_reg <= snap;
`endif
        end
        S_PLACE: begin
          top_x     <= new_x_reg;
          top_width <= new_w_reg;
          level     <= level_inc;
          done      <= 1'b1;
`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
          perfect   <= snap_reg;
`endif
          if (level_inc == 5'(MAX_LEVEL)) begin
            win       <= 1'b1;
            state_reg <= S_WIN;
          end else begin
            state_reg <= S_MOVE;
          end
        end
        S_OVER:  state_reg <= S_OVER;
        S_WIN:   state_reg <= S_WIN;
        default: state_reg <= S_MOVE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_stacker.sv
// Directed bench for block_stacker, built with MAX_LEVEL = 2 so that the win
// path can be reached in two placements.
`timescale 1ns/1ps
module tb_block_stacker;

  logic       clk = 1'b0;
  logic       reset;
  logic       drop;
  logic [7:0] curr_x;
  logic       enable_x;
  logic [7:0] top_x;
  logic [7:0] top_width;
  logic [4:0] level;
  logic       done;
  logic       perfect;
  logic       game_over;
  logic       win;

  int n_vec = 0;
  int n_err = 0;

  block_stacker #(
    .X_MAX(144), .INIT_X(52), .INIT_WIDTH(40), .MAX_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset), .drop(drop), .curr_x(curr_x),
    .enable_x(enable_x), .top_x(top_x), .top_width(top_width),
    .level(level), .done(done), .perfect(perfect),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
    $display("vec %0d %s obs=%0d exp=%0d", n_vec, tag, obs, exp_v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Present a drop so that it is accepted at the next edge (edge N).
  task automatic do_drop(input logic [7:0] x);
    drop   = 1'b1;
    curr_x = x;
    step();
    drop   = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    drop   = 1'b0;
    curr_x = 8'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_top_x", 32'(top_x), 32'd52);
    chk("rst_width", 32'(top_width), 32'd40);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_enable", 32'(enable_x), 32'd1);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_win", 32'(win), 32'd0);

    // Right overhang: x=60 -> overlap [60,92)
    do_drop(8'd60);
    step();
    chk("ro_enable_low", 32'(enable_x), 32'd0);
    chk("ro_done_early", 32'(done), 32'd0);
    step();
    chk("ro_done", 32'(done), 32'd1);
    chk("ro_top_x", 32'(top_x), 32'd60);
    chk("ro_width", 32'(top_width), 32'd32);
    chk("ro_level", 32'(level), 32'd1);
    chk("ro_perfect", 32'(perfect), 32'd0);
    step();
    chk("ro_done_pulse", 32'(done), 32'd0);
    chk("ro_enable_back", 32'(enable_x), 32'd1);

    // Left overhang: x=30 -> overlap [52,70)
    do_reset();
    do_drop(8'd30);
    step();
    step();
    chk("lo_done", 32'(done), 32'd1);
    chk("lo_top_x", 32'(top_x), 32'd52);
    chk("lo_width", 32'(top_width), 32'd18);
    chk("lo_level", 32'(level), 32'd1);

    // Miss: x=100 lies past the right end (92)
    do_reset();
    do_drop(8'd100);
    step();
    chk("miss_game_over", 32'(game_over), 32'd1);
    chk("miss_no_done", 32'(done), 32'd0);
    step();
    chk("miss_enable", 32'(enable_x), 32'd0);
    chk("miss_done2", 32'(done), 32'd0);
    chk("miss_top_x", 32'(top_x), 32'd52);
    chk("miss_width", 32'(top_width), 32'd40);
    do_drop(8'd52);
    step();
    step();
    step();
    chk("miss_ignored_level", 32'(level), 32'd0);
    chk("miss_ignored_done", 32'(done), 32'd0);
    chk("miss_sticky", 32'(game_over), 32'd1);

    // Position beyond X_MAX is still evaluated: x=200 misses
    do_reset();
    do_drop(8'd200);
    step();
    chk("xmax_game_over", 32'(game_over), 32'd1);

    // Snap candidate: x=53
    do_reset();
    do_drop(8'd53);
    step();
    step();
    chk("snap_done", 32'(done), 32'd1);
`ifdef BLOCK_STACKER_PERFECT_SNAP_EN
    chk("snap_top_x", 32'(top_x), 32'd52);
    chk("snap_width", 32'(top_width), 32'd40);
    chk("snap_perfect", 32'(perfect), 32'd1);
`else
    chk("snap_top_x", 32'(top_x), 32'd53);
    chk("snap_width", 32'(top_width), 32'd39);
    chk("snap_perfect", 32'(perfect), 32'd0);
`endif
    step();
    chk("snap_perfect_pulse", 32'(perfect), 32'd0);

    // Win after two placements at x=52
    do_reset();
    do_drop(8'd52);
    step();
    step();
    chk("win1_done", 32'(done), 32'd1);
    chk("win1_level", 32'(level), 32'd1);
    chk("win1_win", 32'(win), 32'd0);
    step();
    chk("win1_enable", 32'(enable_x), 32'd1);
    do_drop(8'd52);
    step();
    step();
    chk("win2_done", 32'(done), 32'd1);
    chk("win2_level", 32'(level), 32'd2);
    chk("win2_win", 32'(win), 32'd1);
    step();
    step();
    chk("win_enable_low", 32'(enable_x), 32'd0);
    chk("win_sticky", 32'(win), 32'd1);
    do_drop(8'd60);
    step();
    step();
    chk("win_frozen_level", 32'(level), 32'd2);
    chk("win_frozen_x", 32'(top_x), 32'd52);

    // Reset while the drop is in CALC: the placement is discarded
    do_reset();
    do_drop(8'd70);
    do_reset();
    chk("rc_top_x", 32'(top_x), 32'd52);
    chk("rc_width", 32'(top_width), 32'd40);
    chk("rc_level", 32'(level), 32'd0);
    chk("rc_enable", 32'(enable_x), 32'd1);
    chk("rc_done", 32'(done), 32'd0);
    chk("rc_perfect", 32'(perfect), 32'd0);
    chk("rc_game_over", 32'(game_over), 32'd0);
    chk("rc_win", 32'(win), 32'd0);
    step();
    step();
    step();
    chk("rc_discarded_done", 32'(done), 32'd0);
    chk("rc_discarded_level", 32'(level), 32'd0);
    chk("rc_discarded_x", 32'(top_x), 32'd52);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
